// File: rtl/instruction_fetch.sv
// RV32I fetch stage: drives the synchronous instruction ROM address, tags returning words
// with their PC and hands {pc, instr} to decode through a 2-entry valid/ready buffer.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        infl_vld_q, infl_vld_d;
   logic [31:0] infl_pc_q, infl_pc_d;
   entry_t      fifo_q [2];
   entry_t      fifo_d [2];
   logic        hd_q, hd_d;
   logic [1:0]  count_q, count_d;

   logic        pop, push, issue, tail;
   logic [2:0]  credit;

   assign out_valid = (count_q != 2'd0);
   assign out_pc    = fifo_q[hd_q].pc;
   assign out_instr = fifo_q[hd_q].instr;
   assign rom_addr  = fetch_pc_q;

   always_comb begin
      pop        = out_valid & out_ready;
      push       = infl_vld_q & ~redirect_valid;
      // Entries already buffered or in flight, net of this cycle's pop, must leave room.
      credit     = {1'b0, count_q} + {2'b00, infl_vld_q} - {2'b00, pop};
      issue      = ~redirect_valid & (credit < 3'd2);
      tail       = hd_q ^ count_q[0];

      fetch_pc_d = fetch_pc_q;
      infl_vld_d = 1'b0;
      infl_pc_d  = infl_pc_q;
      fifo_d     = fifo_q;
      hd_d       = hd_q;
      count_d    = count_q;

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~32'h3;
         count_d    = 2'd0;
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            infl_vld_d = 1'b1;
            infl_pc_d  = fetch_pc_q;
         end
         if (push) begin
            fifo_d[tail].pc    = infl_pc_q;
            fifo_d[tail].instr = rom_rdata;
         end
         if (pop) hd_d = ~hd_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         infl_vld_q <= 1'b0;
         infl_pc_q  <= 32'h0;
         hd_q       <= 1'b0;
         count_q    <= 2'd0;
         for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         infl_vld_q <= infl_vld_d;
         infl_pc_q  <= infl_pc_d;
         hd_q       <= hd_d;
         count_q    <= count_d;
         fifo_q     <= fifo_d;
      end
   end

   // The credit check on issue should make this unreachable.
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(push && count_q == 2'd2 && !pop));

endmodule
